// File: rtl/decode_exec_unit.sv
// Decode/execute slice of the single-cycle MIPS-subset CPU.
// Contains the control decoder, the 32-bit ALU and the falling-edge PC register.
module decode_exec_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_en,
   input  logic [31:0] pc_next,
   output logic [31:0] pc,
   input  logic [5:0]  inst_op,
   input  logic [5:0]  inst_funct,
   input  logic [31:0] alu_x,
   input  logic [31:0] alu_y,
   output logic [3:0]  ctr_aluop,
   output logic        ctr_rf_dst,
   output logic        ctr_rf_we,
   output logic        ctr_branch,
   output logic        ctr_jump,
   output logic        ctr_mem_we,
   output logic        ctr_mem_to_reg,
   output logic        ctr_alu_src,
   output logic        ctr_shift,
   output logic        ctr_branch_eq,
   output logic        ctr_branch_leq,
   output logic        ctr_jump_reg,
   output logic        ctr_jal,
   output logic        ctr_usign,
   output logic        ctr_sys,
   output logic        ctr_shift_var,
   output logic        ctr_load_imm,
   output logic        ctr_store_half,
   output logic [31:0] alu_r1,
   output logic [31:0] alu_r2,
   output logic        alu_eq,
   output logic        alu_leq
);

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_MUL  = 4'd3;
   localparam logic [3:0] ALU_DIV  = 4'd4;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;

   // PC updates on the falling edge so fetch/decode settle in the first half-cycle.
   logic [31:0] pc_reg;

   always_ff @(negedge clk) begin
      if (rst) begin
         pc_reg <= PC_RESET;
      end else if (pc_en) begin
         pc_reg <= pc_next;
      end
   end

   assign pc = pc_reg;

   logic r_write;

   always_comb begin
      ctr_aluop      = ALU_SLL;
      ctr_rf_dst     = 1'b0;
      ctr_rf_we      = 1'b0;
      ctr_branch     = 1'b0;
      ctr_jump       = 1'b0;
      ctr_mem_we     = 1'b0;
      ctr_mem_to_reg = 1'b0;
      ctr_alu_src    = 1'b0;
      ctr_shift      = 1'b0;
      ctr_branch_eq  = 1'b0;
      ctr_branch_leq = 1'b0;
      ctr_jump_reg   = 1'b0;
      ctr_jal        = 1'b0;
      ctr_usign      = 1'b0;
      ctr_sys        = 1'b0;
      ctr_shift_var  = 1'b0;
      ctr_load_imm   = 1'b0;
      ctr_store_half = 1'b0;
      r_write        = 1'b0;
      case (inst_op)
         6'd0: begin
            // r_write covers rf_dst/rf_we for every R-type that writes a register
            r_write = 1'b1;
            case (inst_funct)
               6'd0:  begin ctr_shift = 1'b1; ctr_aluop = ALU_SLL; end
               6'd2:  begin ctr_shift = 1'b1; ctr_aluop = ALU_SRL; end
               6'd3:  begin ctr_shift = 1'b1; ctr_aluop = ALU_SRA; end
               6'd4:  begin ctr_shift = 1'b1; ctr_shift_var = 1'b1; ctr_aluop = ALU_SLL; end
               6'd6:  begin ctr_shift = 1'b1; ctr_shift_var = 1'b1; ctr_aluop = ALU_SRL; end
               6'd7:  begin ctr_shift = 1'b1; ctr_shift_var = 1'b1; ctr_aluop = ALU_SRA; end
               6'd8:  begin ctr_jump_reg = 1'b1; r_write = 1'b0; end
               6'd12: begin ctr_sys = 1'b1; r_write = 1'b0; end
               6'd24: ctr_aluop = ALU_MUL;
               6'd26: ctr_aluop = ALU_DIV;
               6'd32, 6'd33: ctr_aluop = ALU_ADD;
               6'd34, 6'd35: ctr_aluop = ALU_SUB;
               6'd36: ctr_aluop = ALU_AND;
               6'd37: ctr_aluop = ALU_OR;
               6'd38: ctr_aluop = ALU_XOR;
               6'd39: ctr_aluop = ALU_NOR;
               6'd42: ctr_aluop = ALU_SLT;
               6'd43: ctr_aluop = ALU_SLTU;
               default: r_write = 1'b0;
            endcase
            ctr_rf_dst = r_write;
            ctr_rf_we  = r_write;
         end
         6'd2: ctr_jump = 1'b1;
         6'd3: begin ctr_jump = 1'b1; ctr_jal = 1'b1; ctr_rf_we = 1'b1; end
         6'd4: begin ctr_branch = 1'b1; ctr_branch_eq = 1'b1; ctr_aluop = ALU_SUB; end
         6'd5: begin ctr_branch = 1'b1; ctr_aluop = ALU_SUB; end
         6'd6: begin ctr_branch = 1'b1; ctr_branch_leq = 1'b1; ctr_aluop = ALU_SUB; end
         6'd8, 6'd9: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_aluop = ALU_ADD; end
         6'd10: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_aluop = ALU_SLT; end
         6'd11: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_aluop = ALU_SLTU; end
         6'd12: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_usign = 1'b1; ctr_aluop = ALU_AND; end
         6'd13: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_usign = 1'b1; ctr_aluop = ALU_OR; end
         6'd14: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_usign = 1'b1; ctr_aluop = ALU_XOR; end
         6'd15: begin ctr_rf_we = 1'b1; ctr_load_imm = 1'b1; end
         6'd35: begin ctr_alu_src = 1'b1; ctr_rf_we = 1'b1; ctr_mem_to_reg = 1'b1; ctr_aluop = ALU_ADD; end
         6'd41: begin ctr_alu_src = 1'b1; ctr_mem_we = 1'b1; ctr_store_half = 1'b1; ctr_aluop = ALU_ADD; end
         6'd43: begin ctr_alu_src = 1'b1; ctr_mem_we = 1'b1; ctr_aluop = ALU_ADD; end
         default: ;
      endcase
   end

   logic [31:0] and_r;
   logic [31:0] or_r;
   logic [31:0] xor_r;
   logic [31:0] nor_r;

   for (genvar gi = 0; gi < 32; gi++) begin : g_bitwise
      assign and_r[gi] = alu_x[gi] & alu_y[gi];
      assign or_r[gi]  = alu_x[gi] | alu_y[gi];
      assign xor_r[gi] = alu_x[gi] ^ alu_y[gi];
      assign nor_r[gi] = ~(alu_x[gi] | alu_y[gi]);
   end

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   logic [63:0] prod;
   assign prod = {{32{alu_x[31]}}, alu_x} * {{32{alu_y[31]}}, alu_y};

   logic               div_zero;
   logic               div_ovf;
   logic signed [31:0] quot;
   logic signed [31:0] rem;

   assign div_zero = (alu_y == 32'h0);
   assign div_ovf  = (alu_x == 32'h8000_0000) && (alu_y == 32'hFFFF_FFFF);

   // Divide-by-zero and INT_MIN/-1 are steered away from the divider.
   always_comb begin
      quot = 32'sh0;
      rem  = 32'sh0;
      if (div_zero) begin
         quot = -32'sd1;
         rem  = $signed(alu_x);
      end else if (div_ovf) begin
         quot = 32'sh8000_0000;
         rem  = 32'sh0;
      end else begin
         quot = $signed(alu_x) / $signed(alu_y);
         rem  = $signed(alu_x) % $signed(alu_y);
      end
   end

   logic [4:0] shamt;
   assign shamt = alu_y[4:0];

   always_comb begin
      alu_r1 = 32'h0;
      alu_r2 = 32'h0;
      case (ctr_aluop)
         ALU_SLL:  alu_r1 = alu_x << shamt;
         ALU_SRA:  alu_r1 = $signed(alu_x) >>> shamt;
         ALU_SRL:  alu_r1 = alu_x >> shamt;
         ALU_MUL:  begin alu_r1 = prod[31:0]; alu_r2 = prod[63:32]; end
         ALU_DIV:  begin alu_r1 = quot; alu_r2 = rem; end
         ALU_ADD:  alu_r1 = alu_x + alu_y;
         ALU_SUB:  alu_r1 = alu_x - alu_y;
         ALU_AND:  alu_r1 = and_r;
         ALU_OR:   alu_r1 = or_r;
         ALU_XOR:  alu_r1 = xor_r;
         ALU_NOR:  alu_r1 = nor_r;
         ALU_SLT:  alu_r1 = {31'h0, $signed(alu_x) < $signed(alu_y)};
         ALU_SLTU: alu_r1 = {31'h0, alu_x < alu_y};
         default:  alu_r1 = 32'h0;
      endcase
   end

   assign alu_eq  = (alu_x == alu_y);
   assign alu_leq = ($signed(alu_x) <= $signed(alu_y));

endmodule

// File: tb/tb_decode_exec_unit.sv
// Self-checking bench for decode_exec_unit: PC register timing, ALU results,
// full decode sweep and branch flags, driven through expectation queues.
module tb_decode_exec_unit;

   logic        clk;
   logic        rst;
   logic        pc_en;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic [5:0]  inst_op;
   logic [5:0]  inst_funct;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [3:0]  ctr_aluop;
   logic        ctr_rf_dst, ctr_rf_we, ctr_branch, ctr_jump, ctr_mem_we, ctr_mem_to_reg;
   logic        ctr_alu_src, ctr_shift, ctr_branch_eq, ctr_branch_leq, ctr_jump_reg, ctr_jal;
   logic        ctr_usign, ctr_sys, ctr_shift_var, ctr_load_imm, ctr_store_half;
   logic [31:0] alu_r1;
   logic [31:0] alu_r2;
   logic        alu_eq;
   logic        alu_leq;

   int n_cmp = 0;
   int n_err = 0;

   decode_exec_unit #(.PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .pc_en(pc_en), .pc_next(pc_next), .pc(pc),
      .inst_op(inst_op), .inst_funct(inst_funct), .alu_x(alu_x), .alu_y(alu_y),
      .ctr_aluop(ctr_aluop), .ctr_rf_dst(ctr_rf_dst), .ctr_rf_we(ctr_rf_we),
      .ctr_branch(ctr_branch), .ctr_jump(ctr_jump), .ctr_mem_we(ctr_mem_we),
      .ctr_mem_to_reg(ctr_mem_to_reg), .ctr_alu_src(ctr_alu_src), .ctr_shift(ctr_shift),
      .ctr_branch_eq(ctr_branch_eq), .ctr_branch_leq(ctr_branch_leq),
      .ctr_jump_reg(ctr_jump_reg), .ctr_jal(ctr_jal), .ctr_usign(ctr_usign),
      .ctr_sys(ctr_sys), .ctr_shift_var(ctr_shift_var), .ctr_load_imm(ctr_load_imm),
      .ctr_store_half(ctr_store_half), .alu_r1(alu_r1), .alu_r2(alu_r2),
      .alu_eq(alu_eq), .alu_leq(alu_leq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe bit positions in the observed decode vector (below the 4-bit aluop).
   localparam logic [16:0] RFDST = 17'h10000, RFWE = 17'h08000, BR = 17'h04000;
   localparam logic [16:0] JMP = 17'h02000, MEMWE = 17'h01000, M2R = 17'h00800;
   localparam logic [16:0] ASRC = 17'h00400, SHF = 17'h00200, BEQ = 17'h00100;
   localparam logic [16:0] BLEQ = 17'h00080, JR = 17'h00040, JAL = 17'h00020;
   localparam logic [16:0] USGN = 17'h00010, SYS = 17'h00008, SHV = 17'h00004;
   localparam logic [16:0] LIMM = 17'h00002, SH = 17'h00001;
   localparam logic [16:0] RR = RFDST | RFWE;

   logic [20:0] dec_obs;
   assign dec_obs = {ctr_aluop, ctr_rf_dst, ctr_rf_we, ctr_branch, ctr_jump, ctr_mem_we,
                     ctr_mem_to_reg, ctr_alu_src, ctr_shift, ctr_branch_eq, ctr_branch_leq,
                     ctr_jump_reg, ctr_jal, ctr_usign, ctr_sys, ctr_shift_var,
                     ctr_load_imm, ctr_store_half};

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [20:0] exp;
   } dec_t;

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r1;
      logic [31:0] r2;
   } alu_t;

   dec_t stim_dec[$];
   dec_t sb_dec[$];
   alu_t stim_alu[$];
   alu_t sb_alu[$];

   task automatic add_dec(input logic [5:0] op, input logic [5:0] funct,
                          input logic [3:0] aluop, input logic [16:0] mask);
      dec_t t;
      t.op = op; t.funct = funct; t.exp = {aluop, mask};
      stim_dec.push_back(t);
   endtask

   task automatic add_alu(input string name, input logic [5:0] funct, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r1, input logic [31:0] r2);
      alu_t t;
      t.name = name; t.funct = funct; t.x = x; t.y = y; t.r1 = r1; t.r2 = r2;
      stim_alu.push_back(t);
   endtask

   task automatic test_reset();
      @(posedge clk);
      rst = 1'b1; pc_en = 1'b0; pc_next = 32'hDEAD_BEEF;
      @(negedge clk); #1;
      n_cmp++;
      if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      @(posedge clk); #1;
      rst = 1'b0; pc_en = 1'b1; pc_next = 32'h4;
      @(negedge clk); #1;
      n_cmp++;
      if (pc !== 32'h4) begin n_err++; $display("FAIL load_pc: got %h expected %h", pc, 32'h4); end
      pc_next = 32'h55;
      @(posedge clk); #1;
      n_cmp++;
      if (pc !== 32'h4) begin n_err++; $display("FAIL posedge_hold: got %h expected %h", pc, 32'h4); end
   endtask

   task automatic test_hold();
      pc_en = 1'b0; pc_next = 32'h100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (pc !== 32'h4) begin n_err++; $display("FAIL hold_%0d: got %h expected %h", i, pc, 32'h4); end
      end
      @(posedge clk); #1;
      rst = 1'b1; pc_en = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if (pc !== 32'h0) begin n_err++; $display("FAIL reset_priority: got %h expected %h", pc, 32'h0); end
      rst = 1'b0; pc_next = 32'h200;
      @(negedge clk); #1;
      n_cmp++;
      if (pc !== 32'h200) begin n_err++; $display("FAIL resume: got %h expected %h", pc, 32'h200); end
   endtask

   task automatic test_alu_arith();
      add_alu("add_wrap", 6'd32, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0);
      add_alu("sub_neg", 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0);
      add_alu("mul_neg", 6'd24, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
      add_alu("div_neg", 6'd26, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);
      add_alu("div_zero", 6'd26, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234);
      while (stim_alu.size() > 0) begin
         alu_t s, e;
         s = stim_alu.pop_front();
         inst_op = 6'd0; inst_funct = s.funct; alu_x = s.x; alu_y = s.y;
         sb_alu.push_back(s);
         #2;
         e = sb_alu.pop_front();
         n_cmp++;
         if (alu_r1 !== e.r1) begin n_err++; $display("FAIL %s r1: got %h expected %h", e.name, alu_r1, e.r1); end
         n_cmp++;
         if (alu_r2 !== e.r2) begin n_err++; $display("FAIL %s r2: got %h expected %h", e.name, alu_r2, e.r2); end
      end
      inst_funct = 6'd34; alu_x = 32'd3; alu_y = 32'd5;
      #2;
      n_cmp++;
      if ({alu_eq, alu_leq} !== 2'b01) begin
         n_err++; $display("FAIL sub_flags: got eq/leq %b expected %b", {alu_eq, alu_leq}, 2'b01);
      end
   endtask

   task automatic test_alu_logic();
      add_alu("sra", 6'd3, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'h0);
      add_alu("srl", 6'd2, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'h0);
      add_alu("sll_wrap", 6'd4, 32'h8000_0001, 32'd33, 32'h0000_0002, 32'h0);
      add_alu("slt", 6'd42, 32'hFFFF_FFFF, 32'd1, 32'h1, 32'h0);
      add_alu("sltu", 6'd43, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
      add_alu("nor", 6'd39, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);
      add_alu("or", 6'd37, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 32'h0);
      while (stim_alu.size() > 0) begin
         alu_t s, e;
         s = stim_alu.pop_front();
         inst_op = 6'd0; inst_funct = s.funct; alu_x = s.x; alu_y = s.y;
         sb_alu.push_back(s);
         #2;
         e = sb_alu.pop_front();
         n_cmp++;
         if (alu_r1 !== e.r1) begin n_err++; $display("FAIL %s r1: got %h expected %h", e.name, alu_r1, e.r1); end
         n_cmp++;
         if (alu_r2 !== e.r2) begin n_err++; $display("FAIL %s r2: got %h expected %h", e.name, alu_r2, e.r2); end
      end
   endtask

   task automatic test_decode();
      add_dec(6'd0, 6'd0, 4'd0, RR | SHF);
      add_dec(6'd0, 6'd2, 4'd2, RR | SHF);
      add_dec(6'd0, 6'd3, 4'd1, RR | SHF);
      add_dec(6'd0, 6'd4, 4'd0, RR | SHF | SHV);
      add_dec(6'd0, 6'd6, 4'd2, RR | SHF | SHV);
      add_dec(6'd0, 6'd7, 4'd1, RR | SHF | SHV);
      add_dec(6'd0, 6'd8, 4'd0, JR);
      add_dec(6'd0, 6'd12, 4'd0, SYS);
      add_dec(6'd0, 6'd24, 4'd3, RR);
      add_dec(6'd0, 6'd26, 4'd4, RR);
      add_dec(6'd0, 6'd32, 4'd5, RR);
      add_dec(6'd0, 6'd33, 4'd5, RR);
      add_dec(6'd0, 6'd34, 4'd6, RR);
      add_dec(6'd0, 6'd35, 4'd6, RR);
      add_dec(6'd0, 6'd36, 4'd7, RR);
      add_dec(6'd0, 6'd37, 4'd8, RR);
      add_dec(6'd0, 6'd38, 4'd9, RR);
      add_dec(6'd0, 6'd39, 4'd10, RR);
      add_dec(6'd0, 6'd42, 4'd11, RR);
      add_dec(6'd0, 6'd43, 4'd12, RR);
      add_dec(6'd0, 6'd1, 4'd0, 17'h0);
      add_dec(6'd0, 6'd63, 4'd0, 17'h0);
      add_dec(6'd2, 6'd32, 4'd0, JMP);
      add_dec(6'd3, 6'd32, 4'd0, JMP | JAL | RFWE);
      add_dec(6'd4, 6'd32, 4'd6, BR | BEQ);
      add_dec(6'd5, 6'd32, 4'd6, BR);
      add_dec(6'd6, 6'd32, 4'd6, BR | BLEQ);
      add_dec(6'd8, 6'd32, 4'd5, ASRC | RFWE);
      add_dec(6'd9, 6'd32, 4'd5, ASRC | RFWE);
      add_dec(6'd10, 6'd32, 4'd11, ASRC | RFWE);
      add_dec(6'd11, 6'd32, 4'd12, ASRC | RFWE);
      add_dec(6'd12, 6'd32, 4'd7, ASRC | RFWE | USGN);
      add_dec(6'd13, 6'd32, 4'd8, ASRC | RFWE | USGN);
      add_dec(6'd14, 6'd32, 4'd9, ASRC | RFWE | USGN);
      add_dec(6'd15, 6'd32, 4'd0, RFWE | LIMM);
      add_dec(6'd35, 6'd32, 4'd5, ASRC | RFWE | M2R);
      add_dec(6'd43, 6'd32, 4'd5, ASRC | MEMWE);
      add_dec(6'd41, 6'd32, 4'd5, ASRC | MEMWE | SH);
      add_dec(6'd63, 6'd32, 4'd0, 17'h0);
      add_dec(6'd1, 6'd0, 4'd0, 17'h0);
      add_dec(6'd7, 6'd0, 4'd0, 17'h0);
      while (stim_dec.size() > 0) begin
         dec_t s, e;
         s = stim_dec.pop_front();
         inst_op = s.op; inst_funct = s.funct;
         sb_dec.push_back(s);
         #2;
         e = sb_dec.pop_front();
         n_cmp++;
         if (dec_obs !== e.exp) begin
            n_err++;
            $display("FAIL decode op=%0d funct=%0d: got %h expected %h", e.op, e.funct, dec_obs, e.exp);
         end
      end
   endtask

   task automatic test_branch_flags();
      inst_op = 6'd4; inst_funct = 6'd0;
      alu_x = 32'h1234; alu_y = 32'h1234;
      #2;
      n_cmp++;
      if ({alu_eq, alu_leq} !== 2'b11) begin
         n_err++; $display("FAIL flags_equal: got eq/leq %b expected %b", {alu_eq, alu_leq}, 2'b11);
      end
      n_cmp++;
      if (alu_r1 !== 32'h0) begin n_err++; $display("FAIL beq_sub: got %h expected %h", alu_r1, 32'h0); end
      alu_x = 32'h1; alu_y = 32'hFFFF_FFFF;
      #2;
      n_cmp++;
      if ({alu_eq, alu_leq} !== 2'b00) begin
         n_err++; $display("FAIL flags_gt: got eq/leq %b expected %b", {alu_eq, alu_leq}, 2'b00);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] functs[4];
      functs[0] = 6'd32; functs[1] = 6'd34; functs[2] = 6'd38; functs[3] = 6'd36;
      for (int i = 0; i < 16; i++) begin
         alu_t s, e;
         logic exp_eq, exp_leq;
         s.name = $sformatf("b2b_%0d", i);
         s.funct = functs[$urandom_range(0, 3)];
         s.x = $urandom; s.y = (i % 5 == 0) ? s.x : $urandom;
         case (s.funct)
            6'd32:   s.r1 = s.x + s.y;
            6'd34:   s.r1 = s.x - s.y;
            6'd38:   s.r1 = s.x ^ s.y;
            default: s.r1 = s.x & s.y;
         endcase
         s.r2 = 32'h0;
         @(posedge clk);
         inst_op = 6'd0; inst_funct = s.funct; alu_x = s.x; alu_y = s.y;
         sb_alu.push_back(s);
         @(negedge clk);
         e = sb_alu.pop_front();
         exp_eq  = (e.x == e.y);
         exp_leq = (e.x == e.y) || (e.x[31] && !e.y[31]) ||
                   ((e.x[31] == e.y[31]) && (e.x < e.y));
         n_cmp++;
         if ({alu_r1, alu_r2} !== {e.r1, e.r2}) begin
            n_err++; $display("FAIL %s: got %h/%h expected %h/%h", e.name, alu_r1, alu_r2, e.r1, e.r2);
         end
         n_cmp++;
         if ({alu_eq, alu_leq} !== {exp_eq, exp_leq}) begin
            n_err++; $display("FAIL %s flags: got %b expected %b", e.name, {alu_eq, alu_leq}, {exp_eq, exp_leq});
         end
      end
   endtask

   initial begin
      rst = 1'b0; pc_en = 1'b0; pc_next = 32'h0;
      inst_op = 6'd0; inst_funct = 6'd0; alu_x = 32'h0; alu_y = 32'h0;
      test_reset();
      test_hold();
      test_alu_arith();
      test_alu_logic();
      test_decode();
      test_branch_flags();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
